// File: rtl/picorv32_lite_core.sv
// picorv32_lite_core
//   Minimal multi-cycle RV32I core. Each instruction runs FETCH -> EXEC and,
//   for loads and stores, an extra MEM state. One valid/ready port carries
//   both instruction fetches and data accesses. Any fault parks the core in
//   an absorbing TRAP state.
// Ports
//   clk        : single clock, rising edge
//   resetn     : asynchronous reset, active HIGH (historical name)
//   trap       : sticky fault indicator
//   mem_valid  : request pending
//   mem_instr  : request is an instruction fetch
//   mem_ready  : slave completes the request on an edge with valid && ready
//   mem_addr   : word-aligned byte address
//   mem_wdata  : store data, byte/half replicated across lanes
//   mem_wstrb  : byte enables, 0 for reads
//   mem_rdata  : read data, sampled on the completing edge
module picorv32_lite_core #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0000_0000,
  parameter logic [31:0] STACKADDR      = 32'hFFFF_FFFF,
  parameter bit          REGS_INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        trap,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_MEM   = 2'd2;
  localparam logic [1:0] S_TRAP  = 2'd3;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d, insn_q, insn_d;
  logic        valid_q, valid_d, instr_q, instr_d, trap_q, trap_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  lsoff_q, lsoff_d;
  logic [31:0] regs_q [32];

  logic        wr_en, illegal;
  logic [31:0] wr_data;

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  alu = alt ? a - b : a + b;
      3'b001:  alu = a << b[4:0];
      3'b010:  alu = {31'd0, sa < sb};
      3'b011:  alu = {31'd0, a < b};
      3'b100:  alu = a ^ b;
      3'b101:  alu = alt ? 32'(sa >>> b[4:0]) : a >> b[4:0];
      3'b110:  alu = a | b;
      default: alu = a & b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] f3);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (f3)
      3'b000:  br_taken = (a == b);
      3'b001:  br_taken = (a != b);
      3'b100:  br_taken = (sa < sb);
      3'b101:  br_taken = (sa >= sb);
      3'b110:  br_taken = (a < b);
      default: br_taken = (a >= b);
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend to the access width.
  function automatic logic [31:0] ld_ext(input logic [31:0] d, input logic [1:0] off,
                                         input logic [2:0] f3);
    logic [31:0] s;
    s = d >> {off, 3'b000};
    case (f3)
      3'b000:  ld_ext = {{24{s[7]}}, s[7:0]};
      3'b001:  ld_ext = {{16{s[15]}}, s[15:0]};
      3'b100:  ld_ext = {24'd0, s[7:0]};
      3'b101:  ld_ext = {16'd0, s[15:0]};
      default: ld_ext = s;
    endcase
  endfunction

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] rs1_v, rs2_v, imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [31:0] pc_plus4, ld_addr, st_addr, jal_tgt, jalr_tgt, br_tgt;

  assign opcode   = insn_q[6:0];
  assign rd       = insn_q[11:7];
  assign f3       = insn_q[14:12];
  assign rs1      = insn_q[19:15];
  assign rs2      = insn_q[24:20];
  assign f7       = insn_q[31:25];
  assign rs1_v    = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
  assign rs2_v    = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
  assign imm_i    = {{20{insn_q[31]}}, insn_q[31:20]};
  assign imm_s    = {{20{insn_q[31]}}, insn_q[31:25], insn_q[11:7]};
  assign imm_b    = {{19{insn_q[31]}}, insn_q[31], insn_q[7], insn_q[30:25], insn_q[11:8], 1'b0};
  assign imm_j    = {{11{insn_q[31]}}, insn_q[31], insn_q[19:12], insn_q[20], insn_q[30:21], 1'b0};
  assign imm_u    = {insn_q[31:12], 12'd0};
  assign pc_plus4 = pc_q + 32'd4;
  assign ld_addr  = rs1_v + imm_i;
  assign st_addr  = rs1_v + imm_s;
  assign jal_tgt  = pc_q + imm_j;
  assign jalr_tgt = ld_addr & ~32'd1;
  assign br_tgt   = pc_q + imm_b;

  always_comb begin
    state_d = state_q;  pc_d    = pc_q;    insn_d  = insn_q;
    valid_d = valid_q;  instr_d = instr_q; addr_d  = addr_q;
    wdata_d = wdata_q;  wstrb_d = wstrb_q; lsoff_d = lsoff_q;
    trap_d  = trap_q;   wr_en   = 1'b0;    wr_data = 32'd0;
    illegal = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          instr_d = 1'b1;
          addr_d  = {pc_q[31:2], 2'b00};
          wstrb_d = 4'd0;
        end else if (mem_ready) begin
          valid_d = 1'b0;
          insn_d  = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_plus4;
        case (opcode)
          OP_LUI:   begin wr_en = 1'b1; wr_data = imm_u; end
          OP_AUIPC: begin wr_en = 1'b1; wr_data = pc_q + imm_u; end
          OP_JAL: begin
            illegal = jal_tgt[1];
            wr_en   = 1'b1;
            wr_data = pc_plus4;
            pc_d    = jal_tgt;
          end
          OP_JALR: begin
            illegal = (f3 != 3'd0) || jalr_tgt[1];
            wr_en   = 1'b1;
            wr_data = pc_plus4;
            pc_d    = jalr_tgt;
          end
          OP_BRANCH: begin
            if (f3[2:1] == 2'b01) illegal = 1'b1;
            else if (br_taken(rs1_v, rs2_v, f3)) begin
              illegal = br_tgt[1];
              pc_d    = br_tgt;
            end
          end
          OP_LOAD: begin
            case (f3)
              3'b000, 3'b100: illegal = 1'b0;
              3'b001, 3'b101: illegal = ld_addr[0];
              3'b010:         illegal = |ld_addr[1:0];
              default:        illegal = 1'b1;
            endcase
            state_d = S_MEM;
            pc_d    = pc_q;
            valid_d = 1'b1;
            instr_d = 1'b0;
            addr_d  = {ld_addr[31:2], 2'b00};
            wstrb_d = 4'd0;
            lsoff_d = ld_addr[1:0];
          end
          OP_STORE: begin
            case (f3)
              3'b000: begin
                wstrb_d = 4'b0001 << st_addr[1:0];
                wdata_d = {4{rs2_v[7:0]}};
              end
              3'b001: begin
                illegal = st_addr[0];
                wstrb_d = 4'b0011 << st_addr[1:0];
                wdata_d = {2{rs2_v[15:0]}};
              end
              3'b010: begin
                illegal = |st_addr[1:0];
                wstrb_d = 4'b1111;
                wdata_d = rs2_v;
              end
              default: illegal = 1'b1;
            endcase
            state_d = S_MEM;
            pc_d    = pc_q;
            valid_d = 1'b1;
            instr_d = 1'b0;
            addr_d  = {st_addr[31:2], 2'b00};
          end
          OP_IMM: begin
            illegal = ((f3 == 3'b001) && (f7 != 7'd0)) ||
                      ((f3 == 3'b101) && (f7 != 7'd0) && (f7 != 7'b0100000));
            wr_en   = 1'b1;
            wr_data = alu(rs1_v, imm_i, f3, (f3 == 3'b101) && insn_q[30]);
          end
          OP_REG: begin
            illegal = !((f7 == 7'd0) ||
                        ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            wr_en   = 1'b1;
            wr_data = alu(rs1_v, rs2_v, f3, insn_q[30]);
          end
          OP_FENCE: wr_en = 1'b0;
          default:  illegal = 1'b1;
        endcase
        // A faulting instruction leaves registers, PC and the bus untouched.
        if (illegal) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
          pc_d    = pc_q;
          wr_en   = 1'b0;
          valid_d = 1'b0;
          instr_d = instr_q;
          addr_d  = addr_q;
          wdata_d = wdata_q;
          wstrb_d = wstrb_q;
          lsoff_d = lsoff_q;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_plus4;
          state_d = S_FETCH;
          if (wstrb_q == 4'd0) begin
            wr_en   = 1'b1;
            wr_data = ld_ext(mem_rdata, lsoff_q, f3);
          end
        end
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q <= S_FETCH;
      pc_q    <= PROGADDR_RESET;
      insn_q  <= 32'd0;
      valid_q <= 1'b0;
      instr_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
      lsoff_q <= 2'd0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      lsoff_q <= lsoff_d;
      trap_q  <= trap_d;
    end
  end

  // Entry 0 is never written; reads of x0 are forced to zero above.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < 32; i++) begin
        if (REGS_INIT_ZERO || (i == 0)) regs_q[i] <= 32'd0;
      end
      if (STACKADDR != 32'hFFFF_FFFF) regs_q[2] <= STACKADDR;
    end else if (wr_en && (rd != 5'd0)) begin
      regs_q[rd] <= wr_data;
    end
  end

  assign trap      = trap_q;
  assign mem_valid = valid_q;
  assign mem_instr = instr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_picorv32_lite_core.sv
module tb_picorv32_lite_core;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        trap, mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  logic        rst2 = 1'b1;
  logic        t2_trap, v2, i2, r2;
  logic [31:0] a2, wd2, rd2;
  logic [3:0]  ws2;

  int tests = 0;
  int fails = 0;
  int stall_cycles = 0;

  always #5 clk = ~clk;

  picorv32_lite_core #(.PROGADDR_RESET(32'h100), .STACKADDR(32'h1000), .REGS_INIT_ZERO(1'b1)) dut (
    .clk(clk), .resetn(resetn), .trap(trap), .mem_valid(mem_valid), .mem_instr(mem_instr),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata));

  picorv32_lite_core dut2 (
    .clk(clk), .resetn(rst2), .trap(t2_trap), .mem_valid(v2), .mem_instr(i2),
    .mem_ready(r2), .mem_addr(a2), .mem_wdata(wd2), .mem_wstrb(ws2), .mem_rdata(rd2));

  // Memory model for the main core: reads only; stores are logged.
  logic [31:0] mem [0:1023];
  logic [31:0] wlog_addr [0:31];
  logic [31:0] wlog_data [0:31];
  logic [3:0]  wlog_strb [0:31];
  logic [31:0] flog [0:63];
  int wcount, fcount, dcount, wait_cnt;

  assign mem_ready = mem_valid && (wait_cnt >= stall_cycles);
  assign mem_rdata = mem[mem_addr[11:2]];

  always @(posedge clk) begin
    if (resetn) begin
      wait_cnt <= 0; wcount <= 0; fcount <= 0; dcount <= 0;
    end else if (mem_valid) begin
      if (!mem_ready) wait_cnt <= wait_cnt + 1;
      else begin
        wait_cnt <= 0;
        if (mem_instr) begin
          if (fcount < 64) flog[fcount] <= mem_addr;
          fcount <= fcount + 1;
        end else begin
          dcount <= dcount + 1;
          if (mem_wstrb != 4'd0) begin
            if (wcount < 32) begin
              wlog_addr[wcount] <= mem_addr;
              wlog_data[wcount] <= mem_wdata;
              wlog_strb[wcount] <= mem_wstrb;
            end
            wcount <= wcount + 1;
          end
        end
      end
    end
  end

  // Request-stability monitor, sampled mid-cycle.
  logic        prev_pend;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_instr;
  int          stable_err;

  always @(negedge clk) begin
    if (resetn) begin
      prev_pend <= 1'b0; stable_err <= 0;
    end else begin
      if (prev_pend && (!mem_valid || mem_addr !== s_addr || mem_wdata !== s_wdata ||
                        mem_wstrb !== s_wstrb || mem_instr !== s_instr))
        stable_err <= stable_err + 1;
      prev_pend <= mem_valid && !mem_ready;
      s_addr <= mem_addr; s_wdata <= mem_wdata; s_wstrb <= mem_wstrb; s_instr <= mem_instr;
    end
  end

  // Second core: default parameters, program is "sw x2,0(x0)" then an illegal word.
  int          w2count;
  logic [31:0] w2data, w2addr;
  assign r2  = v2;
  assign rd2 = (a2 == 32'd0) ? 32'h0020_2023 : 32'd0;

  always @(posedge clk) begin
    if (rst2) w2count <= 0;
    else if (v2 && r2 && !i2 && ws2 != 4'd0) begin
      w2count <= w2count + 1; w2data <= wd2; w2addr <= a2;
    end
  end

  function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_t(input logic [31:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_t(input logic [31:0] imm, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_t(input logic [31:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                      input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] u_t(input logic [31:0] imm20, input logic [4:0] rd, input logic [6:0] op);
    return {imm20[19:0], rd, op};
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] w);
    mem[a[11:2]] = w;
  endtask

  task automatic begin_test();
    @(negedge clk);
    resetn = 1'b1;
    stall_cycles = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
  endtask

  task automatic release_and_run(input int budget);
    int n;
    n = 0;
    resetn = 1'b0;
    while (!trap && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    begin_test();
    repeat (100) @(negedge clk);
    tests++;
    if (trap !== 1'b0 || mem_valid !== 1'b0 || mem_instr !== 1'b0 || mem_addr !== 32'd0 ||
        mem_wdata !== 32'd0 || mem_wstrb !== 4'd0) begin
      fails++;
      $display("FAIL reset_outputs: trap=%b valid=%b instr=%b addr=%h wdata=%h wstrb=%h, required all zero",
               trap, mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb);
    end
    resetn = 1'b0;
    #1;
    tests++;
    if (mem_valid !== 1'b0) begin
      fails++; $display("FAIL release_idle: mem_valid=%b required 0", mem_valid);
    end
    @(posedge clk); #1;
    tests++;
    if (mem_valid !== 1'b1 || mem_instr !== 1'b1 || mem_addr !== 32'h100 || mem_wstrb !== 4'd0) begin
      fails++;
      $display("FAIL first_fetch: valid=%b instr=%b addr=%h wstrb=%h, required 1 1 00000100 0",
               mem_valid, mem_instr, mem_addr, mem_wstrb);
    end
  endtask

  task automatic test_alu();
    logic [31:0] p [$];
    logic [31:0] exp_d [9];
    exp_d = '{32'h2, 32'hFFFFFFF8, 32'h1, 32'h0, 32'hFFFFFFFE, 32'hF, 32'h12345005, 32'hA0, 32'h0};
    begin_test();
    p = {i_t(5, 0, 0, 1, 7'h13), i_t(32'hFFFFFFFD, 0, 0, 2, 7'h13), r_t(0, 2, 1, 0, 3),
         s_t(32'h200, 3, 0, 2), r_t(7'h20, 1, 2, 0, 4), s_t(32'h204, 4, 0, 2),
         r_t(0, 1, 2, 2, 5), s_t(32'h208, 5, 0, 2), r_t(0, 1, 2, 3, 6), s_t(32'h20C, 6, 0, 2),
         i_t(32'h401, 2, 5, 7, 7'h13), s_t(32'h210, 7, 0, 2), i_t(28, 2, 5, 8, 7'h13),
         s_t(32'h214, 8, 0, 2), u_t(32'h12345, 9, 7'h37), r_t(0, 1, 9, 4, 10),
         s_t(32'h218, 10, 0, 2), r_t(0, 1, 1, 1, 11), s_t(32'h21C, 11, 0, 2),
         i_t(7, 0, 0, 0, 7'h13), s_t(32'h220, 0, 0, 2)};
    foreach (p[i]) put(32'h100 + 4 * i, p[i]);
    release_and_run(2000);
    tests++;
    if (trap !== 1'b1 || wcount != 9) begin
      fails++; $display("FAIL alu_end: trap=%b writes=%0d, required trap=1 writes=9", trap, wcount);
    end
    tests++;
    if (wlog_addr[0] !== 32'h200 || wlog_strb[0] !== 4'hF) begin
      fails++; $display("FAIL alu_sw_bus: addr=%h wstrb=%h, required 00000200 f", wlog_addr[0], wlog_strb[0]);
    end
    for (int k = 0; k < 9; k++) begin
      tests++;
      if (wlog_data[k] !== exp_d[k] || wlog_addr[k] !== 32'h200 + 32'(4 * k)) begin
        fails++;
        $display("FAIL alu_result%0d: addr=%h data=%h, required addr=%h data=%h",
                 k, wlog_addr[k], wlog_data[k], 32'h200 + 32'(4 * k), exp_d[k]);
      end
    end
  endtask

  task automatic test_bytes();
    logic [31:0] p [$];
    logic [31:0] exp_d [5];
    exp_d = '{32'hFFFFFFA5, 32'h000000A5, 32'hFFFF8001, 32'h00008001, 32'h00007F02};
    begin_test();
    p = {i_t(32'hA5, 0, 0, 1, 7'h13), s_t(32'h203, 1, 0, 0),
         i_t(32'h203, 0, 0, 2, 7'h03), s_t(32'h210, 2, 0, 2),
         i_t(32'h203, 0, 4, 3, 7'h03), s_t(32'h214, 3, 0, 2),
         i_t(32'h222, 0, 1, 5, 7'h03), s_t(32'h218, 5, 0, 2),
         i_t(32'h222, 0, 5, 6, 7'h03), s_t(32'h21C, 6, 0, 2),
         i_t(32'h220, 0, 1, 7, 7'h03), s_t(32'h224, 7, 0, 2),
         s_t(32'h206, 1, 0, 1)};
    foreach (p[i]) put(32'h100 + 4 * i, p[i]);
    put(32'h200, 32'hA500_0000);
    put(32'h220, 32'h8001_7F02);
    release_and_run(2000);
    tests++;
    if (trap !== 1'b1 || wcount != 7) begin
      fails++; $display("FAIL bytes_end: trap=%b writes=%0d, required trap=1 writes=7", trap, wcount);
    end
    tests++;
    if (wlog_addr[0] !== 32'h200 || wlog_strb[0] !== 4'h8 || wlog_data[0][31:24] !== 8'hA5) begin
      fails++;
      $display("FAIL bytes_sb: addr=%h wstrb=%h wdata=%h, required 00000200 8 a5xxxxxx",
               wlog_addr[0], wlog_strb[0], wlog_data[0]);
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (wlog_data[k + 1] !== exp_d[k]) begin
        fails++; $display("FAIL bytes_load%0d: got %h required %h", k, wlog_data[k + 1], exp_d[k]);
      end
    end
    tests++;
    if (wlog_addr[6] !== 32'h204 || wlog_strb[6] !== 4'hC || wlog_data[6] !== 32'h00A500A5) begin
      fails++;
      $display("FAIL bytes_sh: addr=%h wstrb=%h wdata=%h, required 00000204 c 00a500a5",
               wlog_addr[6], wlog_strb[6], wlog_data[6]);
    end
  endtask

  task automatic test_control();
    logic [31:0] exp_d [4];
    exp_d = '{32'h14, 32'h55, 32'h3C, 32'h1044};
    begin_test();
    put(32'h100, j_t(32'hFFFFFF10, 0));
    put(32'h10, j_t(8, 1));
    put(32'h18, s_t(32'h200, 1, 0, 2));
    put(32'h1C, i_t(1, 0, 0, 2, 7'h13));
    put(32'h20, b_t(8, 0, 2, 3'b000));
    put(32'h24, b_t(8, 2, 2, 3'b000));
    put(32'h2C, i_t(32'h55, 0, 0, 3, 7'h13));
    put(32'h30, s_t(32'h204, 3, 0, 2));
    put(32'h34, b_t(8, 0, 2, 3'b110));
    put(32'h38, i_t(32'h41, 0, 0, 4, 7'h67));
    put(32'h40, s_t(32'h208, 4, 0, 2));
    put(32'h44, u_t(1, 5, 7'h17));
    put(32'h48, s_t(32'h20C, 5, 0, 2));
    release_and_run(2000);
    tests++;
    if (trap !== 1'b1 || wcount != 4 || fcount != 14) begin
      fails++;
      $display("FAIL ctrl_end: trap=%b writes=%0d fetches=%0d, required 1 4 14", trap, wcount, fcount);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (wlog_data[k] !== exp_d[k]) begin
        fails++; $display("FAIL ctrl_link%0d: got %h required %h", k, wlog_data[k], exp_d[k]);
      end
    end
    tests++;
    if (flog[1] !== 32'h10 || flog[2] !== 32'h18 || flog[5] !== 32'h24 || flog[6] !== 32'h2C ||
        flog[9] !== 32'h38 || flog[10] !== 32'h40 || flog[13] !== 32'h4C) begin
      fails++;
      $display("FAIL ctrl_fetch_seq: %h %h %h %h %h %h %h, required 10 18 24 2c 38 40 4c",
               flog[1], flog[2], flog[5], flog[6], flog[9], flog[10], flog[13]);
    end
  endtask

  task automatic test_stall();
    begin_test();
    stall_cycles = 5;
    put(32'h100, i_t(9, 0, 0, 1, 7'h13));
    put(32'h104, s_t(32'h200, 1, 0, 2));
    put(32'h108, i_t(32'h240, 0, 2, 2, 7'h03));
    put(32'h10C, s_t(32'h204, 2, 0, 2));
    put(32'h240, 32'hDEADBEEF);
    release_and_run(3000);
    tests++;
    if (trap !== 1'b1 || wcount != 2 || fcount != 5 || dcount != 3) begin
      fails++;
      $display("FAIL stall_end: trap=%b writes=%0d fetches=%0d data=%0d, required 1 2 5 3",
               trap, wcount, fcount, dcount);
    end
    tests++;
    if (wlog_data[0] !== 32'd9 || wlog_data[1] !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL stall_data: got %h %h required 00000009 deadbeef", wlog_data[0], wlog_data[1]);
    end
    tests++;
    if (stable_err != 0) begin
      fails++; $display("FAIL stall_stable: %0d unstable cycles, required 0", stable_err);
    end
    stall_cycles = 0;
  endtask

  task automatic test_trap_case(input int id, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input int exp_w, input int exp_f);
    int busy;
    begin_test();
    put(32'h100, w0); put(32'h104, w1); put(32'h108, w2);
    release_and_run(500);
    busy = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_valid !== 1'b0) busy++;
    end
    tests++;
    if (trap !== 1'b1 || busy != 0) begin
      fails++; $display("FAIL trap%0d_state: trap=%b busy_cycles=%0d, required 1 0", id, trap, busy);
    end
    tests++;
    if (wcount != exp_w || dcount != exp_w || fcount != exp_f) begin
      fails++;
      $display("FAIL trap%0d_effects: writes=%0d data=%0d fetches=%0d, required %0d %0d %0d",
               id, wcount, dcount, fcount, exp_w, exp_w, exp_f);
    end
  endtask

  task automatic test_traps();
    test_trap_case(0, i_t(1, 0, 0, 1, 7'h13), s_t(32'h200, 1, 0, 2), 32'h0010_0073, 1, 3);
    test_trap_case(1, i_t(32'h202, 0, 2, 1, 7'h03), 32'h0, 32'h0, 0, 1);
    test_trap_case(2, 32'h0000_0000, 32'h0, 32'h0, 0, 1);
    test_trap_case(3, 32'hFFFF_FFFF, 32'h0, 32'h0, 0, 1);
    test_trap_case(4, j_t(6, 0), 32'h0, 32'h0, 0, 1);
    test_trap_case(5, s_t(32'h202, 0, 0, 2), 32'h0, 32'h0, 0, 1);
    test_trap_case(6, 32'h0000_0073, 32'h0, 32'h0, 0, 1);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    tests++;
    if (trap !== 1'b0 || mem_valid !== 1'b0) begin
      fails++; $display("FAIL trap_reset_clear: trap=%b valid=%b required 0 0", trap, mem_valid);
    end
  endtask

  task automatic test_stack();
    int n;
    begin_test();
    put(32'h100, s_t(0, 2, 0, 2));
    release_and_run(500);
    tests++;
    if (trap !== 1'b1 || wcount != 1 || wlog_addr[0] !== 32'd0 || wlog_data[0] !== 32'h1000) begin
      fails++;
      $display("FAIL stack_sp: writes=%0d addr=%h data=%h, required 1 00000000 00001000",
               wcount, wlog_addr[0], wlog_data[0]);
    end
    @(negedge clk);
    rst2 = 1'b0;
    n = 0;
    while (!t2_trap && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (t2_trap !== 1'b1 || w2count != 1 || w2data !== 32'd0 || w2addr !== 32'd0) begin
      fails++;
      $display("FAIL stack_default: trap=%b writes=%0d addr=%h data=%h, required 1 1 00000000 00000000",
               t2_trap, w2count, w2addr, w2data);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_bytes();
    test_control();
    test_stall();
    test_traps();
    test_stack();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
